// File: rtl/fft16_pkg.sv
// Shared constants, read-side state type and index helper for the 16-point FFT input reorder.
package fft16_pkg;

    localparam int FFT_POINTS = 16;
    localparam int FFT_LOG2   = 4;
    localparam int DEF_N      = 16;
    localparam int DEF_Q      = 8;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_SEND
    } rd_state_e;

    function automatic logic [FFT_LOG2-1:0] bitrev4(input logic [FFT_LOG2-1:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

endpackage

// File: rtl/fft16_input_reorder_if.sv
// Sample-in / butterfly-pair-out handshake bundle; slave is the reorder block, master the environment.
interface fft16_input_reorder_if
    import fft16_pkg::*;
#(
    parameter int N = DEF_N
);
    logic [N-1:0] i_re;
    logic [N-1:0] i_im;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] o_in0_re;
    logic [N-1:0] o_in0_im;
    logic [N-1:0] o_in1_re;
    logic [N-1:0] o_in1_im;
    logic         o_valid;
    logic         i_ready;
    logic         o_first;

    modport slave (
        input  i_re, i_im, i_valid, i_ready,
        output o_ready, o_in0_re, o_in0_im, o_in1_re, o_in1_im, o_valid, o_first
    );

    modport master (
        output i_re, i_im, i_valid, i_ready,
        input  o_ready, o_in0_re, o_in0_im, o_in1_re, o_in1_im, o_valid, o_first
    );
endinterface

// File: rtl/fft16_reorder_bank.sv
// 16-entry complex register bank: one write port, two registered read ports sharing one enable.
module fft16_reorder_bank
    import fft16_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                we,
    input  logic [FFT_LOG2-1:0] waddr,
    input  logic [N-1:0]        wr_re,
    input  logic [N-1:0]        wr_im,
    input  logic                re,
    input  logic [FFT_LOG2-1:0] raddr0,
    input  logic [FFT_LOG2-1:0] raddr1,
    output logic [N-1:0]        rd0_re,
    output logic [N-1:0]        rd0_im,
    output logic [N-1:0]        rd1_re,
    output logic [N-1:0]        rd1_im
);
    logic [N-1:0] mem_re_q [FFT_POINTS];
    logic [N-1:0] mem_im_q [FFT_POINTS];
    logic [N-1:0] rd0_re_q, rd0_re_d, rd0_im_q, rd0_im_d;
    logic [N-1:0] rd1_re_q, rd1_re_d, rd1_im_q, rd1_im_d;

    // Storage needs no reset: the owner's full flags decide when contents are meaningful.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_re_q[waddr] <= wr_re;
            mem_im_q[waddr] <= wr_im;
        end
    end

    always_comb begin
        rd0_re_d = rd0_re_q;
        rd0_im_d = rd0_im_q;
        rd1_re_d = rd1_re_q;
        rd1_im_d = rd1_im_q;
        if (re) begin
            rd0_re_d = mem_re_q[raddr0];
            rd0_im_d = mem_im_q[raddr0];
            rd1_re_d = mem_re_q[raddr1];
            rd1_im_d = mem_im_q[raddr1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd0_re_q <= '0;
            rd0_im_q <= '0;
            rd1_re_q <= '0;
            rd1_im_q <= '0;
        end else begin
            rd0_re_q <= rd0_re_d;
            rd0_im_q <= rd0_im_d;
            rd1_re_q <= rd1_re_d;
            rd1_im_q <= rd1_im_d;
        end
    end

    assign rd0_re = rd0_re_q;
    assign rd0_im = rd0_im_q;
    assign rd1_re = rd1_re_q;
    assign rd1_im = rd1_im_q;
endmodule

// File: rtl/fft16_input_reorder.sv
// Ping-pong frame buffer feeding bit-reversed operand pairs to the first radix-2 stage.
// Optional macro FFT16_IN_SCALE_EN halves each sample on write for headroom.
module fft16_input_reorder
    import fft16_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int Q = DEF_Q
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fft16_input_reorder_if.slave  bus
);
    if (Q >= N) begin : g_q_range
        $error("fft16_input_reorder: Q must be smaller than N");
    end

    logic                wr_bank_q, wr_bank_d;
    logic [FFT_LOG2-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]          full_q, full_d;
    logic                rd_bank_q, rd_bank_d;
    logic [2:0]          pair_q, pair_d;
    rd_state_e           state_q, state_d;
    logic                first_q, first_d;
    logic                out_bank_q, out_bank_d;

    logic                o_ready, accept, wr_last, xfer;
    logic                fetch, fetch_bank;
    logic [2:0]          fetch_pair;
    logic [FFT_LOG2-1:0] fetch_m;
    logic [N-1:0]        wr_re, wr_im;
    logic [1:0][N-1:0]   rd0_re_b, rd0_im_b, rd1_re_b, rd1_im_b;

`ifdef FFT16_IN_SCALE_EN
    assign wr_re = $signed(bus.i_re) >>> 1;
    assign wr_im = $signed(bus.i_im) >>> 1;
`else
    assign wr_re = bus.i_re;
    assign wr_im = bus.i_im;
`endif

    assign o_ready = !full_q[wr_bank_q];
    assign accept  = bus.i_valid && o_ready;
    assign wr_last = accept && (wr_cnt_q == 4'd15);
    assign xfer    = (state_q == RD_SEND) && bus.i_ready;

    // The next pair is fetched on the same edge that transfers the current one,
    // so SEND repeats back-to-back; LOAD only appears when starting from IDLE.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        full_d     = full_q;
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        pair_d     = pair_q;
        first_d    = first_q;
        out_bank_d = out_bank_q;
        fetch      = 1'b0;
        fetch_bank = rd_bank_q;
        fetch_pair = pair_q;

        if (accept) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_last) begin
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end
        end

        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) state_d = RD_LOAD;
            end
            RD_LOAD: begin
                fetch   = 1'b1;
                state_d = RD_SEND;
            end
            RD_SEND: begin
                if (xfer) begin
                    if (pair_q != 3'd7) begin
                        pair_d     = pair_q + 3'd1;
                        fetch      = 1'b1;
                        fetch_pair = pair_q + 3'd1;
                    end else begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        pair_d            = 3'd0;
                        first_d           = 1'b0;
                        if (full_q[~rd_bank_q]) begin
                            fetch      = 1'b1;
                            fetch_bank = ~rd_bank_q;
                            fetch_pair = 3'd0;
                        end else begin
                            state_d = RD_IDLE;
                        end
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        if (fetch) begin
            out_bank_d = fetch_bank;
            first_d    = (fetch_pair == 3'd0);
        end
    end

    assign fetch_m = bitrev4({fetch_pair, 1'b0});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            state_q    <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            pair_q     <= '0;
            first_q    <= 1'b0;
            out_bank_q <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            pair_q     <= pair_d;
            first_q    <= first_d;
            out_bank_q <= out_bank_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft16_reorder_bank #(.N(N)) u_bank (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .we     (accept && (wr_bank_q == 1'(b))),
            .waddr  (wr_cnt_q),
            .wr_re  (wr_re),
            .wr_im  (wr_im),
            .re     (fetch && (fetch_bank == 1'(b))),
            .raddr0 (fetch_m),
            .raddr1 (fetch_m | 4'd8),
            .rd0_re (rd0_re_b[b]),
            .rd0_im (rd0_im_b[b]),
            .rd1_re (rd1_re_b[b]),
            .rd1_im (rd1_im_b[b])
        );
    end

    assign bus.o_ready  = o_ready;
    assign bus.o_valid  = (state_q == RD_SEND);
    assign bus.o_first  = first_q;
    assign bus.o_in0_re = rd0_re_b[out_bank_q];
    assign bus.o_in0_im = rd0_im_b[out_bank_q];
    assign bus.o_in1_re = rd1_re_b[out_bank_q];
    assign bus.o_in1_im = rd1_im_b[out_bank_q];
endmodule

// File: tb/tb_fft16_input_reorder.sv
// Directed bench for fft16_input_reorder: frames of tagged samples, pairs checked against a hand-written bit-reversal table.
module tb_fft16_input_reorder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  int in_f = 0, in_k = 0, in_cnt = 0;
  int out_f = 0, out_p = 0, out_cnt = 0;

  // First-stage operand index m for pair p (in1 uses m+8).
  int m_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft16_input_reorder_if #(.N(16)) bus ();

  fft16_input_reorder #(.N(16), .Q(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] scl(input logic [15:0] v);
`ifdef FFT16_IN_SCALE_EN
    return $signed(v) >>> 1;
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] sre(input int f, input int k);
    return 16'(((f & 15) << 12) | ((k & 15) << 8));
  endfunction

  function automatic logic [15:0] sim(input int f, input int k);
    return 16'(((f & 15) << 4) | (k & 15));
  endfunction

  function automatic logic [64:0] exp_pair(input int f, input int p);
    int m;
    m = m_tab[p];
    return {scl(sre(f, m)), scl(sim(f, m)), scl(sre(f, m + 8)), scl(sim(f, m + 8)), (p == 0)};
  endfunction

  function automatic logic [64:0] obs_pair();
    return {bus.o_in0_re, bus.o_in0_im, bus.o_in1_re, bus.o_in1_im, bus.o_first};
  endfunction

  // One cycle: drive inputs, check any pair about to transfer, then advance past the edge.
  task automatic step(input bit vld, input bit rdy);
    bit xf, ac;
    bus.i_valid = vld;
    bus.i_re    = sre(in_f, in_k);
    bus.i_im    = sim(in_f, in_k);
    bus.i_ready = rdy;
    xf = bus.o_valid && rdy;
    ac = vld && bus.o_ready;
    if (xf) begin
      chk("pair", obs_pair(), exp_pair(out_f, out_p));
      out_cnt++;
      if (out_p == 7) begin
        out_p = 0;
        out_f++;
      end else begin
        out_p++;
      end
    end
    if (ac) begin
      in_cnt++;
      if (in_k == 15) begin
        in_k = 0;
        in_f++;
      end else begin
        in_k++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input bit rdy);
    int tgt, g;
    tgt = in_cnt + n;
    g = 0;
    while (in_cnt < tgt && g < 200) begin
      step(1'b1, rdy);
      g++;
    end
    chk("send_timeout", in_cnt, tgt);
  endtask

  task automatic drain(input int tgt);
    int g;
    g = 0;
    while (out_cnt < tgt && g < 200) begin
      step(1'b0, 1'b1);
      g++;
    end
    chk("drain_timeout", out_cnt, tgt);
  endtask

  initial begin
    int lows, base_in, base_out, g;
    bit seen7;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_re    = '0;
    bus.i_im    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {bus.o_valid, bus.o_first, bus.o_ready, obs_pair()}, {1'b0, 1'b0, 1'b1, 65'h0});
    rst = 1'b0;
    step(1'b0, 1'b1);
    chk("post_reset_outs", {bus.o_valid, bus.o_ready, obs_pair()}, {1'b0, 1'b1, 65'h0});

    // Single frame, latency of first pair
    send(16, 1'b1);
    chk("lat_edge0_valid", bus.o_valid, 1'b0);
    step(1'b0, 1'b1);
    chk("lat_edge1_valid", bus.o_valid, 1'b0);
    step(1'b0, 1'b1);
    chk("lat_edge2_valid", bus.o_valid, 1'b1);
    chk("lat_edge2_first", bus.o_first, 1'b1);
    drain(8);
    step(1'b0, 1'b1);
    chk("idle_after_frame", bus.o_valid, 1'b0);

    // Two frames back-to-back, o_ready must stay high
    lows = 0;
    base_in = in_cnt + 32;
    g = 0;
    while (in_cnt < base_in && g < 100) begin
      if (!bus.o_ready) lows++;
      step(1'b1, 1'b1);
      g++;
    end
    chk("b2b_ready_lows", lows, 0);
    drain(24);

    // Stall on pair 2 for five cycles
    send(16, 1'b1);
    g = 0;
    while (!(bus.o_valid && out_p == 2) && g < 50) begin
      step(1'b0, 1'b1);
      g++;
    end
    chk("reach_pair2", out_p, 2);
    repeat (5) begin
      step(1'b0, 1'b0);
      chk("hold_pair2", {bus.o_valid, obs_pair()}, {1'b1, exp_pair(out_f, 2)});
    end
    drain(32);

    // Downstream blocked, three frames offered: third must stall
    base_in  = in_cnt;
    base_out = out_cnt;
    g = 0;
    while (in_cnt < base_in + 48 && g < 60) begin
      step(1'b1, 1'b0);
      g++;
    end
    chk("stall_accepted", in_cnt - base_in, 32);
    chk("stall_ready_low", bus.o_ready, 1'b0);
    chk("stall_out_none", out_cnt, base_out);
    seen7 = 1'b0;
    g = 0;
    while ((in_cnt < base_in + 48 || out_cnt < base_out + 24) && g < 200) begin
      if (!seen7 && bus.o_valid && out_p == 7) begin
        chk("ready_before_p7", bus.o_ready, 1'b0);
        step(in_cnt < base_in + 48, 1'b1);
        chk("ready_after_p7", bus.o_ready, 1'b1);
        seen7 = 1'b1;
      end else begin
        step(in_cnt < base_in + 48, 1'b1);
      end
      g++;
    end
    chk("release_in", in_cnt - base_in, 48);
    chk("release_out", out_cnt - base_out, 24);

    // Reset after sample 9 discards the partial frame
    send(10, 1'b1);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    #2;
    chk("mid_reset_outs", {bus.o_valid, bus.o_first, bus.o_ready}, {1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_f++;
    in_k  = 0;
    out_f = in_f;
    out_p = 0;
    base_out = out_cnt;
    send(16, 1'b1);
    drain(base_out + 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
